led_ctl: RTL and testbench

//   Bussed LED output controller: the write-side counterpart of the bussed switch

---
 rtl/led_ctl.sv | 129 ++++++++++++
 tb/tb_led_ctl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_ctl.sv
`default_nettype none
// ============================================================================
// Module : led_ctl
// Bussed LED output controller with synchronized bus capture and per-bit blink.
// Rev    : 1.0
// ============================================================================
module led_ctl #(
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_DIV   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_n,
    input  logic       write_n,
    input  logic       addr,
    input  logic [7:0] data,
    output logic [7:0] leds
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]      ce_sync_q;
    logic [SYNC_STAGES-1:0]      we_sync_q;
    logic [SYNC_STAGES-1:0]      addr_sync_q;
    logic [SYNC_STAGES-1:0][7:0] data_sync_q;

    logic       ce_n_s, write_n_s, addr_s, strobe_s;
    logic [7:0] data_s;

    state_t               state_q, state_d;
    logic [7:0]           shadow_data_q, shadow_data_d;
    logic                 shadow_addr_q, shadow_addr_d;
    logic [7:0]           led_reg_q, led_reg_d;
    logic [7:0]           blink_mask_q, blink_mask_d;
    logic [BLINK_DIV-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_clr;
    logic                 phase;
    logic [7:0]           leds_q, leds_d;

    // All bus signals share one depth so addr/data stay aligned with the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_sync_q   <= '1;
            we_sync_q   <= '1;
            addr_sync_q <= '0;
            data_sync_q <= '0;
        end else begin
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ce_n};
            we_sync_q   <= {we_sync_q[SYNC_STAGES-2:0], write_n};
            addr_sync_q <= {addr_sync_q[SYNC_STAGES-2:0], addr};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data};
        end
    end

    assign ce_n_s    = ce_sync_q[SYNC_STAGES-1];
    assign write_n_s = we_sync_q[SYNC_STAGES-1];
    assign addr_s    = addr_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign strobe_s  = ~ce_n_s & ~write_n_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shadow_data_q <= 8'h00;
            shadow_addr_q <= 1'b0;
            led_reg_q     <= 8'h00;
            blink_mask_q  <= 8'h00;
            blink_cnt_q   <= '0;
            leds_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            shadow_data_q <= shadow_data_d;
            shadow_addr_q <= shadow_addr_d;
            led_reg_q     <= led_reg_d;
            blink_mask_q  <= blink_mask_d;
            blink_cnt_q   <= blink_cnt_d;
            leds_q        <= leds_d;
        end
    end

    // Shadow only follows the bus while the strobe is seen active, so the
    // post-release bus value can never overwrite the last valid write data.
    always_comb begin
        state_d       = state_q;
        shadow_data_d = shadow_data_q;
        shadow_addr_d = shadow_addr_q;
        led_reg_d     = led_reg_q;
        blink_mask_d  = blink_mask_q;
        blink_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strobe_s) begin
                    shadow_data_d = data_s;
                    shadow_addr_d = addr_s;
                    state_d       = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (strobe_s) begin
                    shadow_data_d = data_s;
                    shadow_addr_d = addr_s;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (shadow_addr_q) begin
                    blink_mask_d = shadow_data_q;
                    blink_clr    = 1'b1;
                end else begin
                    led_reg_d = shadow_data_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign blink_cnt_d = blink_clr ? '0 : blink_cnt_q + BLINK_DIV'(1);
    assign phase       = blink_cnt_q[BLINK_DIV-1];
    assign leds_d      = led_reg_q & (~blink_mask_q | {8{phase}});
    assign leds        = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_led_ctl.sv
`default_nettype none
// ============================================================================
// Module : tb_led_ctl
// Scoreboard bench for led_ctl: expected LED changes (value + edge) are queued
// by the driver and popped by a monitor whenever the LED output changes.
// Rev    : 1.0
// ============================================================================
module tb_led_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_n;
    logic       write_n;
    logic       addr;
    logic [7:0] data;
    logic [7:0] leds;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    led_ctl #(
        .SYNC_STAGES(2),
        .BLINK_DIV  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ce_n   (ce_n),
        .write_n(write_n),
        .addr   (addr),
        .data   (data),
        .leds   (leds)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every LED change must match the head of the expected queue.
    initial begin : monitor
        logic [7:0] prev;
        exp_t       e;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en && (leds !== prev)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: leds=%02h at edge %0d, none expected", leds, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (leds !== e.val || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL leds_update: got %02h at edge %0d, expected %02h at edge %0d",
                                 leds, cyc, e.val, e.cyc);
                    end
                end
                prev = leds;
            end
        end
    end

    task automatic push_exp(input logic [7:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; returns the edge count at strobe release.
    task automatic bus_write(input logic a, input logic [7:0] d, input int hold, output int rel);
        addr    = a;
        data    = d;
        ce_n    = 1'b0;
        write_n = 1'b0;
        repeat (hold) @(negedge clk);
        ce_n    = 1'b1;
        write_n = 1'b1;
        rel     = cyc;
    endtask

    initial begin : driver
        int rel, rel2, s;
        reset   = 1'b1;
        ce_n    = 1'b1;
        write_n = 1'b1;
        addr    = 1'b0;
        data    = 8'h00;
        wait_cycles(2);
        reset = 1'b0;

        n_checks++;
        if (leds !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_leds: got %02h, expected 00", leds);
        end
        mon_en = 1'b1;

        // Plain LED write, 5-edge latency from release
        bus_write(1'b0, 8'hA5, 4, rel);
        push_exp(8'hA5, rel + 5);
        wait_cycles(12);

        // Blink mask 0F over all-on LEDs; 8-cycle half periods with BLINK_DIV=4
        bus_write(1'b0, 8'hFF, 4, rel);
        push_exp(8'hFF, rel + 5);
        wait_cycles(12);
        bus_write(1'b1, 8'h0F, 4, rel);
        push_exp(8'hF0, rel + 5);
        push_exp(8'hFF, rel + 13);
        push_exp(8'hF0, rel + 21);
        push_exp(8'hFF, rel + 29);
        push_exp(8'hF0, rel + 37);
        push_exp(8'hFF, rel + 39);
        wait_until(rel + 30);
        bus_write(1'b1, 8'h00, 4, rel2);
        wait_cycles(40);

        // Last data within one strobe wins; ce_n-only / write_n-only toggles ignored
        addr    = 1'b0;
        data    = 8'h11;
        ce_n    = 1'b0;
        write_n = 1'b0;
        wait_cycles(3);
        data = 8'h22;
        wait_cycles(3);
        ce_n    = 1'b1;
        write_n = 1'b1;
        rel     = cyc;
        push_exp(8'h22, rel + 5);
        data = 8'h99;
        for (int i = 0; i < 4; i++) begin
            ce_n = 1'b0;
            wait_cycles(3);
            ce_n = 1'b1;
            wait_cycles(2);
        end
        addr    = 1'b1;
        write_n = 1'b0;
        wait_cycles(5);
        write_n = 1'b1;
        wait_cycles(12);

        // Reset while ACTIVE discards the write
        s       = cyc;
        addr    = 1'b0;
        data    = 8'h3C;
        ce_n    = 1'b0;
        write_n = 1'b0;
        wait_cycles(4);
        push_exp(8'h00, s + 5);
        reset   = 1'b1;
        ce_n    = 1'b1;
        write_n = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(20);

        // Back-to-back writes with a 2-cycle gap
        bus_write(1'b0, 8'h01, 3, rel);
        push_exp(8'h01, rel + 5);
        wait_cycles(2);
        bus_write(1'b0, 8'h02, 3, rel2);
        push_exp(8'h02, rel2 + 5);
        wait_cycles(20);

        n_checks++;
        if (leds !== 8'h02) begin
            n_fail++;
            $display("FAIL final_leds: got %02h, expected 02", leds);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expected: %0d updates never seen, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
